// File: rtl/spi_regfile_peripheral.sv
// SPI (mode 0) slave exposing a small register file to the clk domain.
// Frames are 1 + ADDR_W + DATA_W bits, MSB first: R/W (1 = write), address, data.
// Writes commit when chip select rises after a complete frame. Reads return the
// addressed register on CIPO during the data phase of the same frame.
//
// Ports:
//   clk, rst      system clock, asynchronous active-high reset
//   SCLK, COPI    SPI clock and data from the controller (asynchronous to clk)
//   nCS           active-low chip select
//   CIPO          serial read data, CIPO_oe its output enable
//   regs_out      flattened register file, register k at [k*DATA_W +: DATA_W]
//   wr_pulse      one-clk strobe per register commit, wr_addr its address
//   frame_err     sticky malformed-frame flag
module spi_regfile_peripheral #(
    parameter int                NUM_REGS = 5,
    parameter int                ADDR_W   = 7,
    parameter int                DATA_W   = 8,
    parameter logic [DATA_W-1:0] RST_VAL  = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       SCLK,
    input  logic                       COPI,
    input  logic                       nCS,
    output logic                       CIPO,
    output logic                       CIPO_oe,
    output logic [NUM_REGS*DATA_W-1:0] regs_out,
    output logic                       wr_pulse,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic                       frame_err
);

    localparam int F  = 1 + ADDR_W + DATA_W;
    localparam int CW = $clog2(F + 2);
    localparam logic [CW-1:0] F_CNT     = CW'(F);
    localparam logic [CW-1:0] ADDR_DONE = CW'(1 + ADDR_W);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

    // Synchronizers: stages [0],[1] resolve metastability, [2] is the edge reference.
    logic [2:0] sclk_sy, ncs_sy;
    logic [1:0] copi_sy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sy <= 3'b000;
            ncs_sy  <= 3'b111;
            copi_sy <= 2'b00;
        end else begin
            sclk_sy <= {sclk_sy[1:0], SCLK};
            ncs_sy  <= {ncs_sy[1:0], nCS};
            copi_sy <= {copi_sy[0], COPI};
        end
    end

    logic sclk_rise, sclk_fall, ncs_fall, ncs_rise, copi_s;
    assign sclk_rise = sclk_sy[1] & ~sclk_sy[2];
    assign sclk_fall = ~sclk_sy[1] & sclk_sy[2];
    assign ncs_fall  = ~ncs_sy[1] & ncs_sy[2];
    assign ncs_rise  = ncs_sy[1] & ~ncs_sy[2];
    assign copi_s    = copi_sy[1];

    state_t              state;
    logic [CW-1:0]       cnt;
    logic [F-1:0]        sr;
    logic [DATA_W-1:0]   dout;
    logic                cipo_q, oe_q;
    logic [1:0]          warm;
    logic                commit_req;
    logic [ADDR_W-1:0]   commit_addr;
    logic [DATA_W-1:0]   commit_data;
    logic [DATA_W-1:0]   regs [NUM_REGS];

    // If nCS is already low when rst releases, the synchronizer refill looks like
    // a fall; ignore falls until the pipeline holds real pin values so a frame
    // interrupted by reset is never picked up half-way.
    logic armed;
    assign armed = (warm == 2'd3);

    logic [F-1:0]      sr_nxt;
    logic [CW-1:0]     cnt_nxt;
    logic [ADDR_W-1:0] addr_nxt, addr_cur;
    logic              rw_nxt, rw_cur, addr_ok;
    logic [DATA_W-1:0] rd_sel;

    assign sr_nxt   = {sr[F-2:0], copi_s};
    assign cnt_nxt  = cnt + CW'(1);
    assign addr_nxt = sr_nxt[ADDR_W-1:0];
    assign rw_nxt   = sr_nxt[ADDR_W];
    assign addr_cur = sr[ADDR_W+DATA_W-1:DATA_W];
    assign rw_cur   = sr[F-1];

    // Address decode by comparison loop; out-of-range addresses read as zero
    // and never match for commit.
    always_comb begin
        rd_sel  = '0;
        addr_ok = 1'b0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (addr_nxt == ADDR_W'(k)) rd_sel = regs[k];
            if (addr_cur == ADDR_W'(k)) addr_ok = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            sr          <= '0;
            dout        <= '0;
            cipo_q      <= 1'b0;
            oe_q        <= 1'b0;
            warm        <= 2'd0;
            frame_err   <= 1'b0;
            commit_req  <= 1'b0;
            commit_addr <= '0;
            commit_data <= '0;
        end else begin
            commit_req <= 1'b0;
            oe_q       <= ~ncs_sy[2];
            if (!armed) warm <= warm + 2'd1;

            if (ncs_fall && armed) begin
                state  <= ADDR;
                cnt    <= '0;
                sr     <= '0;
                cipo_q <= 1'b0;
            end else if (ncs_rise) begin
                state  <= IDLE;
                cipo_q <= 1'b0;
                case (state)
                    DONE: begin
                        if (rw_cur && addr_ok) begin
                            commit_req  <= 1'b1;
                            commit_addr <= addr_cur;
                            commit_data <= sr[DATA_W-1:0];
                        end
                    end
                    ADDR, DATA: frame_err <= 1'b1;   // short frame
                    default: ;
                endcase
            end else if (state != IDLE) begin
                if (sclk_rise) begin
                    if (state == DONE) begin
                        // Overlong frame: drop it; the later nCS rise finds IDLE.
                        state     <= IDLE;
                        frame_err <= 1'b1;
                    end else begin
                        sr  <= sr_nxt;
                        cnt <= (cnt == F_CNT) ? cnt : cnt_nxt;
                        if (cnt_nxt == ADDR_DONE) begin
                            state <= DATA;
                            dout  <= rw_nxt ? '0 : rd_sel;
                        end
                        if (cnt_nxt == F_CNT) state <= DONE;
                    end
                end else if (sclk_fall && state == DATA) begin
                    cipo_q <= dout[DATA_W-1];
                    dout   <= {dout[DATA_W-2:0], 1'b0};
                end
            end
        end
    end

    assign CIPO    = cipo_q & oe_q & (state == DATA);
    assign CIPO_oe = oe_q;

    // Commit stage: one clk after the nCS rise is seen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_REGS; k++) regs[k] <= RST_VAL;
            wr_pulse <= 1'b0;
            wr_addr  <= '0;
        end else begin
            wr_pulse <= commit_req;
            if (commit_req) begin
                wr_addr <= commit_addr;
                for (int k = 0; k < NUM_REGS; k++)
                    if (commit_addr == ADDR_W'(k)) regs[k] <= commit_data;
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
        assign regs_out[g*DATA_W +: DATA_W] = regs[g];
    end

endmodule

// File: tb/tb_spi_regfile_peripheral.sv
// Bench for spi_regfile_peripheral: a default build (A) and a 16x16 build (B)
// share SCLK/COPI with separate chip selects. Expected commits and read data
// are queued by the stimulus and consumed by independent monitors.
module tb_spi_regfile_peripheral;

    logic clk = 1'b0, rst = 1'b1;
    logic sclk = 1'b0, copi = 1'b0, ncs_a = 1'b1, ncs_b = 1'b1;

    logic         cipo_a, oe_a, wr_pulse_a, frame_err_a;
    logic [39:0]  regs_a;
    logic [6:0]   wr_addr_a;
    logic         cipo_b, oe_b, wr_pulse_b, frame_err_b;
    logic [255:0] regs_b;
    logic [6:0]   wr_addr_b;

    spi_regfile_peripheral dut_a (
        .clk(clk), .rst(rst), .SCLK(sclk), .COPI(copi), .nCS(ncs_a),
        .CIPO(cipo_a), .CIPO_oe(oe_a), .regs_out(regs_a),
        .wr_pulse(wr_pulse_a), .wr_addr(wr_addr_a), .frame_err(frame_err_a)
    );

    spi_regfile_peripheral #(.NUM_REGS(16), .DATA_W(16)) dut_b (
        .clk(clk), .rst(rst), .SCLK(sclk), .COPI(copi), .nCS(ncs_b),
        .CIPO(cipo_b), .CIPO_oe(oe_b), .regs_out(regs_b),
        .wr_pulse(wr_pulse_b), .wr_addr(wr_addr_b), .frame_err(frame_err_b)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    int cyc = 0, rise_cyc = 0, nwr_b = 0, nbits = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {int addr; logic [15:0] data;} wr_t;
    typedef struct {int n; logic [15:0] v;} rd_t;
    wr_t wq[$];
    rd_t rq[$];
    logic        rd_active = 1'b0;
    bit          sel_b = 1'b0;
    logic [15:0] acc = '0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, got, exp);
        end
    endtask

    // Commit monitor for build A.
    always @(negedge clk) begin : mon_wr
        wr_t e;
        if (wr_pulse_a === 1'b1) begin
            if (wq.size() == 0) check("wr_pulse_unexpected", wr_pulse_a, 0);
            else begin
                e = wq.pop_front();
                check("wr_addr", wr_addr_a, e.addr);
                check("wr_data", regs_a[e.addr*8 +: 8], e.data);
                check("wr_latency", cyc - rise_cyc, 4);
            end
        end
        if (wr_pulse_b === 1'b1) nwr_b++;
    end

    // Read monitor: controller samples CIPO on SCLK rise during read data phase.
    always @(posedge sclk) begin : mon_rd
        rd_t e;
        if (rd_active && rq.size() != 0) begin
            acc = {acc[14:0], sel_b ? cipo_b : cipo_a};
            nbits++;
            if (nbits == rq[0].n) begin
                e = rq.pop_front();
                check("rd_data", acc, e.v);
                acc   = '0;
                nbits = 0;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // SCLK = clk/10: 5 clk low, 5 clk high per bit.
    task automatic frame(input bit b, input logic [31:0] bits, input int nb,
                         input int dw, input bit rd, input bit raise = 1'b1);
        sel_b = b;
        if (b) ncs_b = 1'b0; else ncs_a = 1'b0;
        step(6);
        check("cipo_oe", b ? oe_b : oe_a, 1);
        for (int i = nb - 1; i >= 0; i--) begin
            copi = bits[i];
            rd_active = rd && (i < dw);
            step(5);
            sclk = 1'b1;
            step(5);
            sclk = 1'b0;
        end
        step(5);
        rd_active = 1'b0;
        if (raise) begin
            if (b) ncs_b = 1'b1; else ncs_a = 1'b1;
            rise_cyc = cyc;
            step(12);
        end
    endtask

    initial begin
        #10000000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1);
    end

    initial begin
        step(3);
        check("rst_regs", regs_a, 40'h0);
        check("rst_wr_pulse", wr_pulse_a, 0);
        check("rst_wr_addr", wr_addr_a, 0);
        check("rst_frame_err", frame_err_a, 0);
        check("rst_cipo", cipo_a, 0);
        check("rst_cipo_oe", oe_a, 0);
        rst = 1'b0;
        step(6);

        // Basic write addr 0 = 0x5A
        wq.push_back('{addr: 0, data: 16'h5A});
        frame(0, 32'h805A, 16, 8, 0);
        check("w0_reg", regs_a[7:0], 8'h5A);

        // Write addr 4 = 0xC3, read it back
        wq.push_back('{addr: 4, data: 16'hC3});
        frame(0, 32'h84C3, 16, 8, 0);
        rq.push_back('{n: 8, v: 16'hC3});
        frame(0, 32'h0400, 16, 8, 1);
        check("read_no_change", regs_a, 40'hC3_00_00_00_5A);

        // Out-of-range write is silently dropped
        frame(0, 32'h9099, 16, 8, 0);
        check("oor_regs", regs_a, 40'hC3_00_00_00_5A);
        check("oor_frame_err", frame_err_a, 0);

        // Short frame (12 bits of a write to addr 2)
        frame(0, 32'h827, 12, 8, 0);
        check("short_frame_err", frame_err_a, 1);
        check("short_regs", regs_a, 40'hC3_00_00_00_5A);
        wq.push_back('{addr: 2, data: 16'h77});
        frame(0, 32'h8277, 16, 8, 0);
        check("after_err_regs", regs_a, 40'hC3_00_77_00_5A);
        check("err_sticky", frame_err_a, 1);

        // Overlong frame (17 bits, write addr 3)
        frame(0, {15'h0, 17'h10622}, 17, 8, 0);
        check("long_regs", regs_a, 40'hC3_00_77_00_5A);

        // Reset after 9 bits of a write to addr 1; nCS stays low across release
        frame(0, 32'h102, 9, 8, 0, 1'b0);
        rst = 1'b1;
        step(2);
        check("midrst_regs", regs_a, 40'h0);
        check("midrst_frame_err", frame_err_a, 0);
        rst = 1'b0;
        step(10);
        ncs_a = 1'b1;
        step(12);
        check("postrst_frame_err", frame_err_a, 0);
        check("postrst_regs", regs_a, 40'h0);
        wq.push_back('{addr: 1, data: 16'hFF});
        frame(0, 32'h81FF, 16, 8, 0);
        check("postrst_write", regs_a, 40'h00_00_00_FF_00);

        // Reads: in range and out of range
        rq.push_back('{n: 8, v: 16'hFF});
        frame(0, 32'h0100, 16, 8, 1);
        rq.push_back('{n: 8, v: 16'h00});
        frame(0, 32'h1000, 16, 8, 1);

        // Wide build: addr 15 = 0xBEEF, read back
        frame(1, 32'h8FBEEF, 24, 16, 0);
        check("b_reg15", regs_b[255:240], 16'hBEEF);
        check("b_low_regs", regs_b[239:0], 0);
        check("b_wr_count", nwr_b, 1);
        check("b_wr_addr", wr_addr_b, 15);
        rq.push_back('{n: 16, v: 16'hBEEF});
        frame(1, 32'h0F0000, 24, 16, 1);
        check("b_frame_err", frame_err_b, 0);
        check("a_untouched_by_b", regs_a, 40'h00_00_00_FF_00);

        step(20);
        check("wr_queue_drained", wq.size(), 0);
        check("rd_queue_drained", rq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
